// File: rtl/traffic_phase_timer.sv
// ---------------------------------------------------------------------------
// traffic_phase_timer
//
// Round-robin phase sequencer for NUM_DIR traffic approaches. Each served
// approach runs GREEN -> YELLOW -> ALLRED with programmable durations.
// Approaches with no demand are skipped, and the sequencer parks in IDLE
// when nobody is asking.
//
// State table:
//   state     | meaning
//   ----------+-------------------------------------------------------
//   PH_IDLE   | no approach served, waiting for demand on an enable tick
//   PH_GREEN  | approach curr_dir has green (setbit one-hot)
//   PH_YELLOW | approach curr_dir has yellow (yellow one-hot)
//   PH_ALLRED | clearance interval, all approaches red
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   enable      in   tick qualifier; nothing advances when low
//   load        in   latch green_len/yellow_len/allred_len
//   green_len   in   green duration in ticks (0 behaves as 1)
//   yellow_len  in   yellow duration in ticks (0 behaves as 1)
//   allred_len  in   all-red duration in ticks (0 behaves as 1)
//   demand      in   per-approach request, 0 = skip
//   setbit      out  one-hot green select
//   yellow      out  one-hot yellow select
//   curr_dir    out  index of the approach being served
//   phase       out  00 IDLE, 01 GREEN, 10 YELLOW, 11 ALLRED
//   remaining   out  ticks left in the current phase minus one
//   phase_done  out  one-cycle pulse on the edge that ends a phase
//   cycle_done  out  one-cycle pulse when service wraps to a lower/equal index
// ---------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int NUM_DIR    = 4,
    parameter int CNT_W      = 8,
    parameter int GREEN_DEF  = 20,
    parameter int YELLOW_DEF = 3,
    parameter int ALLRED_DEF = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       load,
    input  logic [CNT_W-1:0]           green_len,
    input  logic [CNT_W-1:0]           yellow_len,
    input  logic [CNT_W-1:0]           allred_len,
    input  logic [NUM_DIR-1:0]         demand,
    output logic [NUM_DIR-1:0]         setbit,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [$clog2(NUM_DIR)-1:0] curr_dir,
    output logic [1:0]                 phase,
    output logic [CNT_W-1:0]           remaining,
    output logic                       phase_done,
    output logic                       cycle_done
);

    localparam int DIR_W = $clog2(NUM_DIR);
    localparam logic [DIR_W:0] NUM_DIR_W = (DIR_W+1)'(NUM_DIR);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_ALLRED = 2'b11
    } phase_e;

    phase_e             state_q, state_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   green_len_q, green_len_d;
    logic [CNT_W-1:0]   yellow_len_q, yellow_len_d;
    logic [CNT_W-1:0]   allred_len_q, allred_len_d;
    logic [NUM_DIR-1:0] setbit_q, setbit_d;
    logic [NUM_DIR-1:0] yellow_q, yellow_d;
    logic               phase_done_q, phase_done_d;
    logic               cycle_done_q, cycle_done_d;

    // Counter preload values; a programmed length of 0 runs as 1 tick.
    logic [CNT_W-1:0] green_init, yellow_init, allred_init;

    assign green_init  = (green_len_q  == '0) ? '0 : green_len_q  - CNT_W'(1);
    assign yellow_init = (yellow_len_q == '0) ? '0 : yellow_len_q - CNT_W'(1);
    assign allred_init = (allred_len_q == '0) ? '0 : allred_len_q - CNT_W'(1);

    // Round-robin search. From IDLE the current index itself is eligible
    // first; from ALLRED the search starts one past it and reaches the
    // current index last, so a lone requester gets re-served.
    logic [DIR_W:0]   start_w;
    logic [DIR_W:0]   idx_w;
    logic             found;
    logic [DIR_W-1:0] pick;

    always_comb begin
        start_w = {1'b0, dir_q};
        if (state_q != PH_IDLE) begin
            start_w = {1'b0, dir_q} + (DIR_W+1)'(1);
            if (start_w >= NUM_DIR_W) begin
                start_w = '0;
            end
        end
        idx_w = '0;
        found = 1'b0;
        pick  = dir_q;
        // Descending walk so the closest requester overwrites farther ones.
        for (int k = NUM_DIR - 1; k >= 0; k--) begin
            idx_w = start_w + (DIR_W+1)'(k);
            if (idx_w >= NUM_DIR_W) begin
                idx_w = idx_w - NUM_DIR_W;
            end
            if (demand[idx_w[DIR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx_w[DIR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        rem_d        = rem_q;
        phase_done_d = 1'b0;
        cycle_done_d = 1'b0;
        green_len_d  = load ? green_len  : green_len_q;
        yellow_len_d = load ? yellow_len : yellow_len_q;
        allred_len_d = load ? allred_len : allred_len_q;

        if (enable) begin
            case (state_q)
                PH_IDLE: begin
                    if (found) begin
                        state_d = PH_GREEN;
                        dir_d   = pick;
                        rem_d   = green_init;
                    end
                end
                PH_GREEN: begin
                    if (rem_q == '0) begin
                        phase_done_d = 1'b1;
                        state_d      = PH_YELLOW;
                        rem_d        = yellow_init;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
                PH_YELLOW: begin
                    if (rem_q == '0) begin
                        phase_done_d = 1'b1;
                        state_d      = PH_ALLRED;
                        rem_d        = allred_init;
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
                PH_ALLRED: begin
                    if (rem_q == '0) begin
                        phase_done_d = 1'b1;
                        if (found) begin
                            state_d      = PH_GREEN;
                            dir_d        = pick;
                            rem_d        = green_init;
                            cycle_done_d = (pick <= dir_q);
                        end else begin
                            state_d = PH_IDLE;
                            rem_d   = '0;
                        end
                    end else begin
                        rem_d = rem_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = PH_IDLE;
                    rem_d   = '0;
                end
            endcase
        end

        // Selects are decoded from the next state so they stay registered.
        setbit_d = '0;
        yellow_d = '0;
        if (state_d == PH_GREEN) begin
            setbit_d = NUM_DIR'(1) << dir_d;
        end
        if (state_d == PH_YELLOW) begin
            yellow_d = NUM_DIR'(1) << dir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PH_IDLE;
            dir_q        <= '0;
            rem_q        <= '0;
            green_len_q  <= CNT_W'(GREEN_DEF);
            yellow_len_q <= CNT_W'(YELLOW_DEF);
            allred_len_q <= CNT_W'(ALLRED_DEF);
            setbit_q     <= '0;
            yellow_q     <= '0;
            phase_done_q <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            rem_q        <= rem_d;
            green_len_q  <= green_len_d;
            yellow_len_q <= yellow_len_d;
            allred_len_q <= allred_len_d;
            setbit_q     <= setbit_d;
            yellow_q     <= yellow_d;
            phase_done_q <= phase_done_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    assign setbit     = setbit_q;
    assign yellow     = yellow_q;
    assign curr_dir   = dir_q;
    assign phase      = state_q;
    assign remaining  = rem_q;
    assign phase_done = phase_done_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_timer
//
// Directed bench for traffic_phase_timer with default parameters
// (4 approaches, 8-bit counters, defaults 20/3/1). Expected values are
// hand-derived cycle by cycle. Outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_traffic_phase_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] green_len;
    logic [7:0] yellow_len;
    logic [7:0] allred_len;
    logic [3:0] demand;
    logic [3:0] setbit;
    logic [3:0] yellow;
    logic [1:0] curr_dir;
    logic [1:0] phase;
    logic [7:0] remaining;
    logic       phase_done;
    logic       cycle_done;

    int   n_checks = 0;
    int   n_errors = 0;
    logic sb_bad   = 1'b0;   // green ever seen on approach 0 or 2
    logic excl_bad = 1'b0;   // overlap or multi-hot select ever seen

    always #5 clk = ~clk;

    traffic_phase_timer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .green_len  (green_len),
        .yellow_len (yellow_len),
        .allred_len (allred_len),
        .demand     (demand),
        .setbit     (setbit),
        .yellow     (yellow),
        .curr_dir   (curr_dir),
        .phase      (phase),
        .remaining  (remaining),
        .phase_done (phase_done),
        .cycle_done (cycle_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if ((setbit & 4'b0101) != 4'b0000) sb_bad = 1'b1;
        if ((setbit & yellow) != 4'b0000) excl_bad = 1'b1;
        if ($countones(setbit) > 1 || $countones(yellow) > 1) excl_bad = 1'b1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int exp_rem[7];
        exp_rem = '{3, 2, 2, 1, 1, 0, 0};

        reset = 1'b1; enable = 1'b0; load = 1'b0;
        green_len = 8'd0; yellow_len = 8'd0; allred_len = 8'd0;
        demand = 4'b0000;

        // Reset state
        tick();
        chk("rst_phase", phase, 2'b00);
        chk("rst_dir", curr_dir, 2'd0);
        chk("rst_rem", remaining, 8'd0);
        chk("rst_setbit", setbit, 4'b0000);
        chk("rst_yellow", yellow, 4'b0000);
        chk("rst_pd", phase_done, 1'b0);
        chk("rst_cd", cycle_done, 1'b0);

        // Defaults: 20 green, 3 yellow, 1 all-red, then approach 1
        reset = 1'b0; demand = 4'b1111; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("def_green_sb", setbit, 4'b0001);
            chk("def_green_rem", remaining, 32'(19 - i));
            chk("def_green_pd", phase_done, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("def_yel", yellow, 4'b0001);
            chk("def_yel_sb", setbit, 4'b0000);
            chk("def_yel_rem", remaining, 32'(2 - i));
            chk("def_yel_pd", phase_done, (i == 0) ? 1'b1 : 1'b0);
        end
        tick();
        chk("def_ar_phase", phase, 2'b11);
        chk("def_ar_sb", setbit, 4'b0000);
        chk("def_ar_yel", yellow, 4'b0000);
        chk("def_ar_pd", phase_done, 1'b1);
        tick();
        chk("def_next_sb", setbit, 4'b0010);
        chk("def_next_dir", curr_dir, 2'd1);
        chk("def_next_pd", phase_done, 1'b1);
        chk("def_next_cd", cycle_done, 1'b0);
        chk("def_next_rem", remaining, 8'd19);

        // Skip and wrap: demand 1010, lengths 2/1/1
        reset = 1'b1; tick();
        reset = 1'b0; enable = 1'b0; load = 1'b1;
        green_len = 8'd2; yellow_len = 8'd1; allred_len = 8'd1;
        tick();
        load = 1'b0;
        chk("sw_hold_idle", phase, 2'b00);
        demand = 4'b1010; enable = 1'b1; sb_bad = 1'b0;
        tick();
        chk("sw_g1_dir", curr_dir, 2'd1);
        chk("sw_g1_sb", setbit, 4'b0010);
        chk("sw_g1_rem", remaining, 8'd1);
        tick_n(3);
        chk("sw_ar1", phase, 2'b11);
        tick();
        chk("sw_g3_dir", curr_dir, 2'd3);
        chk("sw_g3_sb", setbit, 4'b1000);
        chk("sw_g3_cd", cycle_done, 1'b0);
        tick_n(3); tick();
        chk("sw_g1b_dir", curr_dir, 2'd1);
        chk("sw_g1b_cd", cycle_done, 1'b1);
        tick_n(3); tick();
        chk("sw_g3b_dir", curr_dir, 2'd3);
        chk("sw_g3b_cd", cycle_done, 1'b0);
        tick_n(3); tick();
        chk("sw_g1c_dir", curr_dir, 2'd1);
        chk("sw_g1c_cd", cycle_done, 1'b1);
        chk("sw_skipped", sb_bad, 1'b0);

        // Enable gating with green_len=4 (loaded mid-green)
        load = 1'b1; green_len = 8'd4;
        tick();
        load = 1'b0;
        chk("eg_old_len", remaining, 8'd0);
        chk("eg_old_phase", phase, 2'b01);
        tick();
        chk("eg_yel", phase, 2'b10);
        tick();
        chk("eg_ar", phase, 2'b11);
        tick();
        chk("eg_g_phase", phase, 2'b01);
        chk("eg_g_dir", curr_dir, 2'd3);
        chk("eg_g_rem", remaining, 8'd3);
        for (int i = 0; i < 7; i++) begin
            enable = (i % 2 == 1);
            tick();
            chk("eg_rem", remaining, 32'(exp_rem[i]));
            chk("eg_phase", phase, 2'b01);
            chk("eg_sb", setbit, 4'b1000);
        end
        enable = 1'b1;
        tick();
        chk("eg_end_phase", phase, 2'b10);
        chk("eg_end_pd", phase_done, 1'b1);
        chk("eg_end_yel", yellow, 4'b1000);
        enable = 1'b0;
        tick();
        chk("eg_hold_pd", phase_done, 1'b0);
        chk("eg_hold_phase", phase, 2'b10);
        chk("eg_hold_yel", yellow, 4'b1000);
        enable = 1'b1;

        // Zero length loaded mid-green
        tick();
        chk("zl_ar", phase, 2'b11);
        tick();
        chk("zl_g_dir", curr_dir, 2'd1);
        chk("zl_g_cd", cycle_done, 1'b1);
        chk("zl_g_rem", remaining, 8'd3);
        load = 1'b1; green_len = 8'd0;
        tick();
        load = 1'b0;
        chk("zl_rem2", remaining, 8'd2);
        tick();
        chk("zl_rem1", remaining, 8'd1);
        tick();
        chk("zl_rem0", remaining, 8'd0);
        chk("zl_still_g", phase, 2'b01);
        tick();
        chk("zl_yel", phase, 2'b10);
        tick();
        chk("zl_ar2", phase, 2'b11);
        tick();
        chk("zl_g1_phase", phase, 2'b01);
        chk("zl_g1_dir", curr_dir, 2'd3);
        chk("zl_g1_rem", remaining, 8'd0);
        tick();
        chk("zl_g1_end", phase, 2'b10);
        chk("zl_g1_pd", phase_done, 1'b1);

        // No demand at all-red end, then single requester from IDLE
        tick();
        chk("nd_ar", phase, 2'b11);
        demand = 4'b0000;
        tick();
        chk("nd_idle", phase, 2'b00);
        chk("nd_pd", phase_done, 1'b1);
        chk("nd_dir", curr_dir, 2'd3);
        chk("nd_sb", setbit, 4'b0000);
        chk("nd_yel", yellow, 4'b0000);
        chk("nd_rem", remaining, 8'd0);
        tick();
        chk("nd_stay", phase, 2'b00);
        chk("nd_stay_pd", phase_done, 1'b0);
        demand = 4'b0100;
        tick();
        chk("nd_g_phase", phase, 2'b01);
        chk("nd_g_sb", setbit, 4'b0100);
        chk("nd_g_dir", curr_dir, 2'd2);
        chk("nd_g_cd", cycle_done, 1'b0);

        // Reset while in yellow
        tick();
        chk("ry_in_yel", phase, 2'b10);
        chk("ry_yel", yellow, 4'b0100);
        reset = 1'b1;
        tick();
        chk("ry_phase", phase, 2'b00);
        chk("ry_yel0", yellow, 4'b0000);
        chk("ry_pd", phase_done, 1'b0);
        chk("ry_dir", curr_dir, 2'd0);
        chk("ry_rem", remaining, 8'd0);
        reset = 1'b0; demand = 4'b1111;
        tick();
        chk("ry_g_phase", phase, 2'b01);
        chk("ry_g_rem", remaining, 8'd19);
        tick_n(19);
        chk("ry_g_last", remaining, 8'd0);
        tick();
        chk("ry_y_phase", phase, 2'b10);
        chk("ry_y_rem", remaining, 8'd2);
        tick_n(2); tick();
        chk("ry_ar_phase", phase, 2'b11);
        chk("ry_ar_rem", remaining, 8'd0);

        chk("excl_onehot", excl_bad, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
Parametrised phase timer for the smart traffic light controller. It replaces the fixed 2-bit counter and 4-entry state decode with a single sequencer for NUM_DIR approaches. Each approach runs a programmable GREEN -> YELLOW -> ALLRED cycle, and approaches with no demand are skipped. It drives one-hot green/yellow selects and completion pulses to the controller FSM.

Parameters:
NUM_DIR, 4, number of approaches (2..8)
CNT_W, 8, width of duration registers and down-counter
GREEN_DEF, 20, green duration in ticks loaded at reset
YELLOW_DEF, 3, yellow duration in ticks loaded at reset
ALLRED_DEF, 1, all-red clearance duration in ticks loaded at reset

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
enable  input  1  tick qualifier; the timer advances only on cycles with enable=1
load  input  1  when high, latch green_len/yellow_len/allred_len
green_len  input  CNT_W  green duration in ticks
yellow_len  input  CNT_W  yellow duration in ticks
allred_len  input  CNT_W  all-red duration in ticks
demand  input  NUM_DIR  per-approach request; 0 = skip that approach
setbit  output  NUM_DIR  one-hot green select; bit i = approach i green
yellow  output  NUM_DIR  one-hot yellow select
curr_dir  output  $clog2(NUM_DIR)  index of the approach being served
phase  output  2  00 IDLE, 01 GREEN, 10 YELLOW, 11 ALLRED
remaining  output  CNT_W  ticks left in the current phase, minus 1
phase_done  output  1  one-cycle pulse on the last tick of any phase
cycle_done  output  1  one-cycle pulse when curr_dir wraps to a lower index

Behaviour:
- Reset (reset=1 at a clk edge) sets:
  - phase=IDLE, curr_dir=0, remaining=0, setbit=0, yellow=0, phase_done=0, cycle_done=0.
  - Duration registers to GREEN_DEF, YELLOW_DEF and ALLRED_DEF.
- Reset has priority over every other input. A reset asserted mid-phase aborts the phase; there is no pulse on that edge.
- Duration registers:
  - load=1 updates the registers on the next edge.
  - New values apply from the next phase entry. The phase in progress is not affected.
  - A length of 0 is treated as 1.
- All outputs are registered, with no combinational path from inputs to outputs.
- IDLE:
  - On an enable tick, go to GREEN with curr_dir = first approach at or after curr_dir with demand=1.
  - If demand=0, stay in IDLE.
- Counter behaviour:
  - On phase entry, remaining = len-1.
  - Each enable tick decrements remaining by 1.
  - When enable=0, everything holds: state, remaining, curr_dir, setbit, yellow.
- Phase end: an enable tick with remaining=0 ends the phase.
  - phase_done=1 on that same edge.
  - GREEN -> YELLOW.
  - YELLOW -> ALLRED.
  - ALLRED -> GREEN of the next approach.
- Next-approach search:
  - Round-robin starting at curr_dir+1, wrapping modulo NUM_DIR, taking the first approach with demand=1.
  - If only curr_dir has demand, re-serve curr_dir.
  - If demand=0 overall, go to IDLE with curr_dir unchanged.
- cycle_done pulses on the ALLRED->GREEN edge when the new curr_dir <= the old curr_dir.
- Output encoding:
  - setbit = one-hot(curr_dir) only in GREEN.
  - yellow = one-hot(curr_dir) only in YELLOW.
  - Both are 0 in ALLRED and IDLE.
  - setbit & yellow is always 0; at most one bit of either is set.
- The demand input is sampled only at the ALLRED end and in IDLE. Dropping demand mid-green does not shorten the phase.
- Phase latency in GREEN is exactly green_len enable ticks; yellow and all-red follow the same rule.

Test Plan:
- Reset and defaults:
  - Stimulus: reset 1 cycle, demand=4'b1111, enable=1 continuously.
  - Response: 1 IDLE cycle, then setbit=4'b0001 for 20 cycles, yellow=4'b0001 for 3, all zero for 1, then setbit=4'b0010.
  - phase_done pulses at cycles 20, 23 and 24 after GREEN entry.
- Skip and wrap:
  - Stimulus: demand=4'b1010, green_len=2, yellow_len=1, allred_len=1.
  - Response: served order is 1, 3, 1, 3.
  - cycle_done pulses on each 3->1 transition; approaches 0 and 2 never get setbit.
- Enable gating:
  - Stimulus: toggle enable 1,0,1,0 during GREEN with green_len=4.
  - Response: GREEN lasts 8 clk cycles; remaining holds on enable=0 cycles.
- Zero length and mid-phase load:
  - Stimulus: load green_len=0 mid-green.
  - Response: the current green completes at the old length; the next green lasts 1 tick.
- No demand:
  - Stimulus: demand=0 during ALLRED.
  - Response: phase goes to IDLE with outputs zero.
  - Then demand=4'b0100 gives GREEN with setbit=4'b0100 on the next enable tick.
- Reset mid-yellow:
  - Stimulus: reset=1 while phase=10.
  - Response: the next edge gives phase=00, yellow=0, no phase_done pulse, and durations restored to defaults.
